// File: rtl/fifo_lite.sv
// fifo_lite: single-clock FIFO with a registered read port, used as the UART TX/RX buffer.
// Define FIFO_LITE_ERR_FLAGS_EN to add registered overflow/underflow pulse outputs.
module fifo_lite #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             full
`ifdef FIFO_LITE_ERR_FLAGS_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = AW'(0) + (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_acc, rd_acc;

  // Status is decoded from the pre-edge count, so full/empty arbitrate simultaneous access.
  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (wr_acc) wr_ptr_d = wr_ptr + 1'b1;
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef FIFO_LITE_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  assign ovf_d = wr_en && full;
  assign unf_d = rd_en && empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_lite.sv
// Self-checking bench for fifo_lite: directed test-plan sequence plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_fifo_lite;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, empty, full;
`ifdef FIFO_LITE_ERR_FLAGS_EN
  logic             overflow, underflow;
`endif

  int checks = 0;
  int failures = 0;

  fifo_lite #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full)
`ifdef FIFO_LITE_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the expected read-port registers.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rd_data;
  logic             m_rd_valid, m_ovf, m_unf;
  int               m_wr_ptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_rd_data = '0; m_rd_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_wr_ptr = 0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_ovf = wr_en && was_full;
      m_unf = rd_en && was_empty;
      m_rd_valid = rd_en && !was_empty;
      if (m_rd_valid) m_rd_data = mq.pop_front();
      if (wr_en && !was_full) begin
        mq.push_back(wr_data);
        m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rd_data", 32'(rd_data), 32'(m_rd_data));
      chk("wr_ptr", 32'(dut.wr_ptr), 32'(m_wr_ptr));
`ifdef FIFO_LITE_ERR_FLAGS_EN
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
`endif
    end
  end

  // One clock: drive at the falling edge, return after the model/compare have settled.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    repeat (3) @(negedge clk);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_empty", 32'(empty), 32'd0);
    chk("fill_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_wr_ptr", 32'(dut.wr_ptr), 32'd0);
    chk("ovf_full", 32'(full), 32'd1);
`ifdef FIFO_LITE_ERR_FLAGS_EN
    chk("ovf_pulse", 32'(overflow), 32'd1);
`endif

    step(1'b0, '0, 1'b1);
    chk("first_valid", 32'(rd_valid), 32'd1);
    chk("first_data", 32'(rd_data), 32'h00);
    chk("first_not_full", 32'(full), 32'd0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_data", 32'(rd_data), 32'h00);

    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    step(1'b0, '0, 1'b1);
    chk("uf_valid", 32'(rd_valid), 32'd0);
    chk("uf_data", 32'(rd_data), 32'h0F);
`ifdef FIFO_LITE_ERR_FLAGS_EN
    chk("uf_pulse", 32'(underflow), 32'd1);
`endif

    for (int i = 0; i < 10; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b1);
      chk("wrap_rd_a", 32'(rd_data), 32'(8'h40 + i));
    end
    for (int i = 0; i < 12; i++) step(1'b1, WIDTH'(8'hA0 + i), 1'b0);
    chk("wrap_wr_ptr", 32'(dut.wr_ptr), 32'd6);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b1);
      chk("wrap_rd_b", 32'(rd_data), 32'(8'hA0 + i));
    end
    chk("five_count", 32'(dut.count_q), 32'd5);
    step(1'b1, 8'h5A, 1'b1);
    chk("simul_count", 32'(dut.count_q), 32'd5);
    chk("simul_data", 32'(rd_data), 32'hA7);

    // Randomized traffic in phases biased toward filling and toward draining.
    for (int ph = 0; ph < 8; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 80 : 20;
      for (int c = 0; c < 200; c++) begin
        step(($urandom_range(99) < wp), WIDTH'($urandom), ($urandom_range(99) < (100 - wp)));
      end
      if (ph == 4) begin
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_valid", 32'(rd_valid), 32'd0);
        chk("midrst_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
      end
    end

    for (int c = 0; c < 300; c++) step($urandom_range(1), WIDTH'($urandom), $urandom_range(1));

    step(1'b0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
